// File: rtl/dram_dma.sv
// dram_dma: block-copy DMA engine plus CPU/DMA arbiter sitting in front of the dram array.
// Copies dma_len words from dma_src to dma_dst. Each word takes one read cycle and then one
// write cycle. CPU requests pass straight through to the dram pins and always take priority.
// The DMA holds its current state on any cycle where the CPU uses the array.
//
// Ports
//   clk, rst_n          system clock (FSM on posedge), async active-low reset
//   cpu_read/cpu_write  CPU access request for this cycle
//   cpu_addr/cpu_d_in   CPU address and write data
//   cpu_d_out           CPU read data (mem_d_out while cpu_read, else 0)
//   dma_start           start pulse, honoured only in idle
//   dma_src/dst/len     copy descriptor, captured when a start is accepted
//   dma_busy            copy in progress (read or write phase)
//   dma_done            one-cycle completion pulse
//   dma_err             sticky range error, cleared by the next accepted start
//   dma_remain          words still to copy
//   mem_read/mem_write  dram strobes (dram writes on negedge of the same cycle)
//   mem_addr/mem_d_in   dram address and write data
//   mem_d_out           dram read data (combinational)
module dram_dma #(
  parameter int unsigned RAM_LO = 16,
  parameter int unsigned RAM_HI = 6144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_d_in,
  output logic [15:0] cpu_d_out,
  input  logic        dma_start,
  input  logic [15:0] dma_src,
  input  logic [15:0] dma_dst,
  input  logic [15:0] dma_len,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_err,
  output logic [15:0] dma_remain,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_d_in,
  input  logic [15:0] mem_d_out
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  localparam logic [16:0] LoBound = 17'(RAM_LO);
  localparam logic [16:0] HiBound = 17'(RAM_HI);

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] buf_q, buf_d;
  logic        err_q, err_d;

  logic        cpu_hit;
  logic [16:0] src_end, dst_end;
  logic        range_err;

  assign cpu_hit = cpu_read | cpu_write;

  // 17-bit end addresses so a huge length cannot wrap back into the legal window.
  assign src_end   = {1'b0, dma_src} + {1'b0, dma_len} - 17'd1;
  assign dst_end   = {1'b0, dma_dst} + {1'b0, dma_len} - 17'd1;
  assign range_err = ({1'b0, dma_src} < LoBound) | ({1'b0, dma_dst} < LoBound) |
                     (src_end > HiBound) | (dst_end > HiBound);

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    buf_d    = buf_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (dma_start) begin
          if (dma_len == 16'd0) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else if (range_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            src_d    = dma_src;
            dst_d    = dma_dst;
            remain_d = dma_len;
            err_d    = 1'b0;
            state_d  = StRd;
          end
        end
      end
      StRd: begin
        if (!cpu_hit) begin
          buf_d   = mem_d_out;
          state_d = StWr;
        end
      end
      StWr: begin
        if (!cpu_hit) begin
          src_d    = src_q + 16'd1;
          dst_d    = dst_q + 16'd1;
          remain_d = remain_q - 16'd1;
          state_d  = (remain_q == 16'd1) ? StDone : StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      src_q    <= 16'd0;
      dst_q    <= 16'd0;
      remain_q <= 16'd0;
      buf_q    <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
    end
  end

  // Arbiter: the CPU owns the pins whenever it asks; the DMA only drives them otherwise.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 16'd0;
    mem_d_in  = 16'd0;
    if (cpu_hit) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_d_in  = cpu_d_in;
    end else if (state_q == StRd) begin
      mem_read = 1'b1;
      mem_addr = src_q;
    end else if (state_q == StWr) begin
      mem_write = 1'b1;
      mem_addr  = dst_q;
      mem_d_in  = buf_q;
    end
  end

  assign cpu_d_out  = cpu_read ? mem_d_out : 16'd0;
  assign dma_busy   = (state_q == StRd) | (state_q == StWr);
  assign dma_done   = (state_q == StDone);
  assign dma_err    = err_q;
  assign dma_remain = remain_q;

endmodule
